// File: rtl/dmem_bridge.sv
// Data-memory bridge between the MEM stage and a valid/ready memory bus.
// Stores are posted through an in-order write buffer; loads stall the core
// until the buffer has drained and the read data has been captured.
module dmem_bridge #(
  parameter int unsigned WB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic [31:0] dataAddr_i,
  input  logic [31:0] storeData_i,
  input  logic [1:0]  store_type_i,
  output logic [31:0] dataInput_o,
  output logic        memStall_o,
  output logic        busValid_o,
  input  logic        busReady_i,
  output logic        busWrite_o,
  output logic [31:0] busAddr_o,
  output logic [31:0] busWdata_o,
  output logic [3:0]  busBe_o,
  input  logic        busRvalid_i,
  input  logic [31:0] busRdata_i
);

  localparam int unsigned PtrW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(WB_DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StWrBus, StRdReq, StRdWait, StRdDone} state_e;

  state_e stateQ, stateD;

  logic [29:0]     addrMem [WB_DEPTH];
  logic [31:0]     dataMem [WB_DEPTH];
  logic [3:0]      beMem   [WB_DEPTH];
  logic [PtrW-1:0] wrPtrQ, rdPtrQ;
  logic [CntW-1:0] countQ, countD;
  logic [31:0]     dataQ;
  logic            full, empty, push, pop;
  logic [31:0]     pushData;
  logic [3:0]      pushBe;

  assign full  = (countQ == CntW'(WB_DEPTH));
  assign empty = (countQ == '0);
  assign push  = memWrite_i && !full;
  // Decoded from state rather than busValid_o to keep the FSM block loop-free.
  assign pop   = (stateQ == StWrBus) && busReady_i;

  // Little-endian lane placement of the store data, done once at push time.
  always_comb begin
    pushBe   = 4'b1111;
    pushData = storeData_i;
    unique case (store_type_i)
      2'b01: begin
        pushBe   = dataAddr_i[1] ? 4'b1100 : 4'b0011;
        pushData = {2{storeData_i[15:0]}};
      end
      2'b10: begin
        pushBe   = 4'b0001 << dataAddr_i[1:0];
        pushData = {4{storeData_i[7:0]}};
      end
      default: ;
    endcase
  end

  // Write-buffer storage; contents need no reset because count guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtrQ] <= dataAddr_i[31:2];
      dataMem[wrPtrQ] <= pushData;
      beMem[wrPtrQ]   <= pushBe;
    end
  end

  // Next occupancy; a refused push (full) never coincides with a counted push.
  always_comb begin
    countD = countQ;
    if (push && !pop) begin
      countD = countQ + CntW'(1);
    end else if (pop && !push) begin
      countD = countQ - CntW'(1);
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + PtrW'(1);
      if (pop)  rdPtrQ <= rdPtrQ + PtrW'(1);
      countQ <= countD;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state and bus outputs; bus fields depend only on state and held inputs,
  // so they stay stable while a request waits for busReady_i.
  always_comb begin
    stateD     = stateQ;
    busValid_o = 1'b0;
    busWrite_o = 1'b0;
    busAddr_o  = '0;
    busWdata_o = '0;
    busBe_o    = '0;
    unique case (stateQ)
      StIdle: begin
        // Draining stores first keeps loads ordered after earlier stores.
        if (!empty || push) begin
          stateD = StWrBus;
        end else if (memRead_i && !memWrite_i) begin
          stateD = StRdReq;
        end
      end
      StWrBus: begin
        busValid_o = 1'b1;
        busWrite_o = 1'b1;
        busAddr_o  = {addrMem[rdPtrQ], 2'b00};
        busWdata_o = dataMem[rdPtrQ];
        busBe_o    = beMem[rdPtrQ];
        if (busReady_i) begin
          stateD = (countD != '0) ? StWrBus : StIdle;
        end
      end
      StRdReq: begin
        busValid_o = 1'b1;
        busAddr_o  = {dataAddr_i[31:2], 2'b00};
        busBe_o    = 4'b1111;
        if (busReady_i) stateD = StRdWait;
      end
      StRdWait: begin
        if (busRvalid_i) stateD = StRdDone;
      end
      StRdDone: stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // Load data register; read data outside RD_WAIT is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataQ <= '0;
    end else if ((stateQ == StRdWait) && busRvalid_i) begin
      dataQ <= busRdata_i;
    end
  end

  assign dataInput_o = dataQ;

  // Stall is combinational so the core freezes in the cycle it presents the request.
  assign memStall_o = !reset &&
                      ((memRead_i && !memWrite_i && (stateQ != StRdDone)) ||
                       (memWrite_i && full));

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed vectors and corner-case
// sequences, then a randomized run against a transaction-level memory model.
module tb_dmem_bridge;

  localparam int unsigned Depth = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [31:0] dataAddr, storeData;
  logic [1:0]  storeType;
  logic [31:0] dataInput;
  logic        memStall, busValid, busWrite;
  logic [31:0] busAddr, busWdata;
  logic [3:0]  busBe;
  wire         busReady, busRvalid;
  wire  [31:0] busRdata;

  logic        autoBus;
  logic        dReady, dRvalid;
  logic [31:0] dRdata;
  logic        aReady, aRvalid;
  logic [31:0] aRdata;
  logic        loadActive;

  assign busReady  = autoBus ? aReady  : dReady;
  assign busRvalid = autoBus ? aRvalid : dRvalid;
  assign busRdata  = autoBus ? aRdata  : dRdata;

  always #5 clk = ~clk;

  dmem_bridge #(.WB_DEPTH(Depth)) dut (
    .clk         (clk),
    .reset       (reset),
    .memRead_i   (memRead),
    .memWrite_i  (memWrite),
    .dataAddr_i  (dataAddr),
    .storeData_i (storeData),
    .store_type_i(storeType),
    .dataInput_o (dataInput),
    .memStall_o  (memStall),
    .busValid_o  (busValid),
    .busReady_i  (busReady),
    .busWrite_o  (busWrite),
    .busAddr_o   (busAddr),
    .busWdata_o  (busWdata),
    .busBe_o     (busBe),
    .busRvalid_i (busRvalid),
    .busRdata_i  (busRdata)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  st;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
  } vec_t;

  vec_t        vecs[8];
  wr_t         expQ[$];
  logic [31:0] refMem[8];
  logic [31:0] busMem[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memInit(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_valid"}, busValid, 0);
    check({tag, "_write"}, busWrite, 0);
    check({tag, "_addr"}, busAddr, 0);
    check({tag, "_wdata"}, busWdata, 0);
    check({tag, "_be"}, busBe, 0);
    check({tag, "_stall"}, memStall, 0);
    check({tag, "_data"}, dataInput, 0);
  endtask

  // Bus responder and monitor: random ready, delayed read data from a memory
  // image updated only by observed write handshakes, spurious rvalid pulses.
  initial begin : busModel
    wr_t         e;
    logic        holdPrev, rdPending, pWrite;
    logic [31:0] pAddr, pWdata, rdWord;
    logic [3:0]  pBe;
    int          rdDelay;
    aReady = 1'b0; aRvalid = 1'b0; aRdata = '0;
    holdPrev = 1'b0; rdPending = 1'b0; rdDelay = 0; rdWord = '0;
    pWrite = 1'b0; pAddr = '0; pWdata = '0; pBe = '0;
    for (int i = 0; i < 8; i++) busMem[i] = memInit(i);
    forever begin
      @(negedge clk);
      if (!autoBus) begin
        holdPrev = 1'b0;
        aReady = 1'b0;
        aRvalid = 1'b0;
      end else begin
        aReady = ($urandom_range(0, 3) != 0);
        if (rdPending && rdDelay == 0) begin
          aRvalid = 1'b1;
          aRdata = rdWord;
          rdPending = 1'b0;
        end else begin
          if (rdPending) rdDelay--;
          aRvalid = !rdPending && ($urandom_range(0, 7) == 0);
          aRdata = $urandom;
        end
        #2;
        if (holdPrev) begin
          check("bus_hold_valid", busValid, 1);
          check("bus_hold_write", busWrite, pWrite);
          check("bus_hold_addr", busAddr, pAddr);
          check("bus_hold_wdata", busWdata, pWdata);
          check("bus_hold_be", busBe, pBe);
        end
        if (busValid) check("bus_addr_align", busAddr[1:0], 0);
        holdPrev = busValid && !aReady;
        pWrite = busWrite; pAddr = busAddr; pWdata = busWdata; pBe = busBe;
        if (busValid && aReady) begin
          if (busWrite) begin
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL bus_unexpected_write: got addr 0x%08h, expected no write", busAddr);
            end else begin
              e = expQ.pop_front();
              check("bus_wr_addr", busAddr, e.addr);
              check("bus_wr_be", busBe, e.be);
              check("bus_wr_wdata", busWdata, e.wdata);
            end
            for (int b = 0; b < 4; b++) begin
              if (busBe[b]) busMem[busAddr[4:2]][b*8 +: 8] = busWdata[b*8 +: 8];
            end
          end else begin
            check("bus_rd_expected", loadActive, 1);
            check("bus_rd_after_writes", expQ.size(), 0);
            check("bus_rd_be", busBe, 4'hF);
            rdPending = 1'b1;
            rdDelay = $urandom_range(0, 2);
            rdWord = busMem[busAddr[4:2]];
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    wr_t         e;
    logic [31:0] a, sd;
    logic [1:0]  st;
    int          op, guard, lane;
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; dataAddr = '0; storeData = '0;
    storeType = '0; autoBus = 1'b0; dReady = 1'b0; dRvalid = 1'b0; dRdata = '0;
    loadActive = 1'b0;

    vecs[0] = '{32'h100, 32'hDEADBEEF, 2'b00, 32'h100, 4'b1111, 32'hDEADBEEF};
    vecs[1] = '{32'h203, 32'h000000AB, 2'b10, 32'h200, 4'b1000, 32'hABABABAB};
    vecs[2] = '{32'h302, 32'h00001234, 2'b01, 32'h300, 4'b1100, 32'h12341234};
    vecs[3] = '{32'h501, 32'h556677C3, 2'b10, 32'h500, 4'b0010, 32'hC3C3C3C3};
    vecs[4] = '{32'h611, 32'h9999BEEF, 2'b01, 32'h610, 4'b0011, 32'hBEEFBEEF};
    vecs[5] = '{32'h70E, 32'h12345678, 2'b11, 32'h70C, 4'b1111, 32'h12345678};
    vecs[6] = '{32'h802, 32'hA1B2C3D4, 2'b00, 32'h800, 4'b1111, 32'hA1B2C3D4};
    vecs[7] = '{32'h900, 32'h00000012, 2'b10, 32'h900, 4'b0001, 32'h12121212};

    doReset();
    #1 checkIdleOutputs("reset");

    // Store formatting, zero-wait bus: presented the cycle after acceptance.
    dReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      memWrite = 1'b1; dataAddr = vecs[i].addr; storeData = vecs[i].data;
      storeType = vecs[i].st;
      #1 check("vec_no_stall", memStall, 0);
      @(negedge clk);
      memWrite = 1'b0;
      #1;
      check("vec_valid", busValid, 1);
      check("vec_write", busWrite, 1);
      check("vec_addr", busAddr, vecs[i].expAddr);
      check("vec_be", busBe, vecs[i].expBe);
      check("vec_wdata", busWdata, vecs[i].expWdata);
      @(negedge clk);
      #1 check("vec_drained", busValid, 0);
    end

    // Full buffer, in-order drain, then a load that waits for the last write.
    @(negedge clk);
    dReady = 1'b0; memWrite = 1'b1; storeType = 2'b00;
    dataAddr = 32'h1000; storeData = 32'h11111111;
    #1 check("full_s1_stall", memStall, 0);
    @(negedge clk);
    dataAddr = 32'h1004; storeData = 32'h22222222;
    #1 check("full_s2_stall", memStall, 0);
    @(negedge clk);
    dataAddr = 32'h1008; storeData = 32'h33333333;
    #1 check("full_s3_stall", memStall, 1);
    @(negedge clk);
    #1 check("full_s3_hold", memStall, 1);
    check("full_head_addr", busAddr, 32'h1000);
    @(negedge clk);
    dReady = 1'b1;
    #1 check("full_pop_cycle_stall", memStall, 1);
    check("full_pop1_addr", busAddr, 32'h1000);
    check("full_pop1_wdata", busWdata, 32'h11111111);
    @(negedge clk);
    #1 check("full_after_pop_stall", memStall, 0);
    check("full_pop2_addr", busAddr, 32'h1004);
    check("full_pop2_valid", busValid, 1);
    @(negedge clk);
    memWrite = 1'b0; memRead = 1'b1; dataAddr = 32'h100C;
    #1 check("full_pop3_addr", busAddr, 32'h1008);
    check("full_pop3_wdata", busWdata, 32'h33333333);
    check("full_pop3_write", busWrite, 1);
    check("full_load_stall", memStall, 1);
    @(negedge clk);
    #1 check("full_idle_gap", busValid, 0);
    @(negedge clk);
    #1 check("full_rd_valid", busValid, 1);
    check("full_rd_write", busWrite, 0);
    check("full_rd_addr", busAddr, 32'h100C);
    @(negedge clk);
    dRvalid = 1'b1; dRdata = 32'h0BADCAFE;
    #1 check("full_rdwait_valid", busValid, 0);
    @(negedge clk);
    dRvalid = 1'b0;
    #1 check("full_rd_stall_low", memStall, 0);
    check("full_rd_data", dataInput, 32'h0BADCAFE);
    @(negedge clk);
    memRead = 1'b0;

    // Load with zero-wait bus: stall exactly three cycles.
    @(negedge clk);
    memRead = 1'b1; dataAddr = 32'h404; dReady = 1'b1;
    #1 check("ld_t0_stall", memStall, 1);
    check("ld_t0_valid", busValid, 0);
    @(negedge clk);
    #1 check("ld_t1_stall", memStall, 1);
    check("ld_t1_valid", busValid, 1);
    check("ld_t1_write", busWrite, 0);
    check("ld_t1_addr", busAddr, 32'h404);
    check("ld_t1_be", busBe, 4'hF);
    @(negedge clk);
    dRvalid = 1'b1; dRdata = 32'hCAFEF00D;
    #1 check("ld_t2_stall", memStall, 1);
    check("ld_t2_valid", busValid, 0);
    @(negedge clk);
    dRvalid = 1'b0; dRdata = '0;
    #1 check("ld_t3_stall", memStall, 0);
    check("ld_t3_data", dataInput, 32'hCAFEF00D);
    @(negedge clk);
    memRead = 1'b0;

    // Read backpressure; a stray rvalid during RD_REQ must be ignored.
    @(negedge clk);
    dReady = 1'b0; memRead = 1'b1; dataAddr = 32'h80A;
    #1 check("bp_idle_valid", busValid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dRvalid = (i == 2); dRdata = 32'hFFFF0000;
      #1 check("bp_valid", busValid, 1);
      check("bp_write", busWrite, 0);
      check("bp_addr", busAddr, 32'h808);
      check("bp_be", busBe, 4'hF);
      check("bp_stall", memStall, 1);
    end
    @(negedge clk);
    dRvalid = 1'b0; dReady = 1'b1;
    #1 check("bp_hs_addr", busAddr, 32'h808);
    check("bp_stray_ignored", dataInput, 32'hCAFEF00D);
    @(negedge clk);
    dReady = 1'b0;
    #1 check("bp_rdwait_valid", busValid, 0);
    check("bp_rdwait_stall", memStall, 1);
    @(negedge clk);
    dRvalid = 1'b1; dRdata = 32'h13572468;
    #1 check("bp_rdwait2_valid", busValid, 0);
    @(negedge clk);
    dRvalid = 1'b0;
    #1 check("bp_done_stall", memStall, 0);
    check("bp_done_data", dataInput, 32'h13572468);
    @(negedge clk);
    memRead = 1'b0;

    // Reset while in RD_WAIT, then a late rvalid.
    @(negedge clk);
    dReady = 1'b1; memRead = 1'b1; dataAddr = 32'hC0C;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_stall_in_reset", memStall, 0);
    @(negedge clk);
    reset = 1'b0; memRead = 1'b0;
    #1 checkIdleOutputs("rst_mid");
    @(negedge clk);
    dRvalid = 1'b1; dRdata = 32'hDEADDEAD;
    @(negedge clk);
    dRvalid = 1'b0;
    #1 check("rst_late_data", dataInput, 0);
    check("rst_late_valid", busValid, 0);
    check("rst_late_stall", memStall, 0);
    @(negedge clk);
    memRead = 1'b1; dataAddr = 32'hC10;
    #1 check("rst_idle_stall", memStall, 1);
    @(negedge clk);
    #1 check("rst_idle_to_rdreq", busValid, 1);
    @(negedge clk);
    dRvalid = 1'b1; dRdata = 32'h2468ACE0;
    @(negedge clk);
    dRvalid = 1'b0;
    #1 check("rst_next_load_data", dataInput, 32'h2468ACE0);
    @(negedge clk);
    memRead = 1'b0;

    // Reset discards buffered stores.
    @(negedge clk);
    dReady = 1'b0; memWrite = 1'b1; storeType = 2'b00;
    dataAddr = 32'h1234; storeData = 32'h55;
    @(negedge clk);
    dataAddr = 32'h1238;
    @(negedge clk);
    memWrite = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; dReady = 1'b1;
    #1 check("discard_valid0", busValid, 0);
    @(negedge clk);
    #1 check("discard_valid1", busValid, 0);
    @(negedge clk);
    memWrite = 1'b1; dataAddr = 32'h1240; storeData = 32'h77;
    #1 check("discard_new_stall", memStall, 0);
    @(negedge clk);
    memWrite = 1'b0;
    #1 check("discard_new_addr", busAddr, 32'h1240);
    check("discard_new_wdata", busWdata, 32'h77);
    @(negedge clk);
    #1 check("discard_empty", busValid, 0);

    // Randomized run against the reference memory model.
    for (int i = 0; i < 8; i++) refMem[i] = memInit(i);
    autoBus = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      op = $urandom_range(0, 9);
      a = 32'h1000 + 32'($urandom_range(0, 31));
      if (op < 6) begin
        sd = $urandom;
        st = 2'($urandom_range(0, 3));
        memWrite = 1'b1; memRead = ($urandom_range(0, 3) == 0);
        dataAddr = a; storeData = sd; storeType = st;
        #1 check("rnd_store_stall", memStall, (expQ.size() == Depth));
        guard = 0;
        while (memStall && guard < 200) begin
          @(negedge clk);
          #1 check("rnd_store_stall", memStall, (expQ.size() == Depth));
          guard++;
        end
        if (memStall) begin
          checks++;
          errors++;
          $display("FAIL rnd_store_timeout: got stall after %0d cycles, expected accept", guard);
        end else begin
          e.addr = {a[31:2], 2'b00};
          if (st == 2'b10) begin
            lane = int'(a[1:0]);
            refMem[a[4:2]][lane*8 +: 8] = sd[7:0];
            e.be = 4'(1 << lane);
            e.wdata = {4{sd[7:0]}};
          end else if (st == 2'b01) begin
            lane = a[1] ? 2 : 0;
            refMem[a[4:2]][lane*8 +: 16] = sd[15:0];
            e.be = a[1] ? 4'b1100 : 4'b0011;
            e.wdata = {2{sd[15:0]}};
          end else begin
            refMem[a[4:2]] = sd;
            e.be = 4'b1111;
            e.wdata = sd;
          end
          expQ.push_back(e);
        end
      end else if (op < 9) begin
        memWrite = 1'b0; memRead = 1'b1; dataAddr = a; loadActive = 1'b1;
        #1 check("rnd_load_stall", memStall, 1);
        guard = 0;
        while (memStall && guard < 300) begin
          @(negedge clk);
          #1 guard++;
        end
        if (memStall) begin
          checks++;
          errors++;
          $display("FAIL rnd_load_timeout: got stall after %0d cycles, expected data", guard);
        end else begin
          check("rnd_load_data", dataInput, refMem[a[4:2]]);
        end
        loadActive = 1'b0;
      end else begin
        memWrite = 1'b0; memRead = 1'b0;
        #1 check("rnd_idle_stall", memStall, 0);
      end
    end

    @(negedge clk);
    memWrite = 1'b0; memRead = 1'b0;
    guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", expQ.size(), 0);
    @(negedge clk);
    #1 check("drain_bus_idle", busValid, 0);
    autoBus = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
